// File: rtl/sobel_frame_ctrl_if.sv
// Pixel handshake from the memory controller and line-buffer write bus toward preprocess.
// The slave side is the frame sequencer; the master side is the surrounding datapath.
interface sobel_frame_ctrl_if #(
  parameter int CW = 10
);
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          lb_we_o;
  logic [1:0]    lb_sel_o;
  logic [CW-1:0] lb_addr_o;
  logic          win_valid_o;
  logic [CW-1:0] row_o;
  logic [CW-1:0] col_o;

  modport master (
    output pix_valid_i,
    input  pix_ready_o, lb_we_o, lb_sel_o, lb_addr_o, win_valid_o, row_o, col_o
  );

  modport slave (
    input  pix_valid_i,
    output pix_ready_o, lb_we_o, lb_sel_o, lb_addr_o, win_valid_o, row_o, col_o
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: accepts the pixel stream, tracks row/column, drives the rotating
// line-buffer writes and flags when a complete 3x3 window is available.
module sobel_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   stall_i,
  sobel_frame_ctrl_if.slave      bus,
  output logic                   done_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] WIN_MIN  = CW'(2);

  state_t        state, state_next;
  logic [CW-1:0] row, col;
  logic [1:0]    sel;
  logic          acc;
  logic          clear;
  logic          last_col;

  assign state_o  = state;
  assign last_col = (col == LAST_COL);

  always_comb begin
    state_next      = state;
    bus.pix_ready_o = ((state == FILL) || (state == RUN)) && !stall_i && !abort_i;
    acc             = bus.pix_valid_i && bus.pix_ready_o;
    clear           = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = FILL;
          clear      = 1'b1;
        end
      end
      FILL: begin
        if (abort_i) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else if (acc && (row == CW'(1)) && last_col) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else if (acc && (row == LAST_ROW) && last_col) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        clear      = abort_i;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      col             <= '0;
      sel             <= '0;
      done_o          <= 1'b0;
      bus.lb_we_o     <= 1'b0;
      bus.lb_sel_o    <= '0;
      bus.lb_addr_o   <= '0;
      bus.row_o       <= '0;
      bus.col_o       <= '0;
      bus.win_valid_o <= 1'b0;
    end else begin
      state           <= state_next;
      done_o          <= (state_next == DONE);
      bus.lb_we_o     <= acc;
      bus.win_valid_o <= acc && (row >= WIN_MIN) && (col >= WIN_MIN);

      // Write-side outputs only update on acceptance so they hold between strobes.
      if (acc) begin
        bus.lb_sel_o  <= sel;
        bus.lb_addr_o <= col;
        bus.row_o     <= row;
        bus.col_o     <= col;
      end

      if (clear) begin
        row <= '0;
        col <= '0;
        sel <= '0;
      end else if (acc) begin
        if (last_col) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
          sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x4 frame: the stimulus queues the
// expected line-buffer writes and a negedge monitor checks each one as it appears.
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [1:0] sel;
    logic [2:0] row;
    logic [2:0] col;
    logic       win;
    logic       done;
    int         gap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       stall_i;
  logic       done_o;
  logic [2:0] state_o;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  exp_t expq[$];

  sobel_frame_ctrl_if #(.CW(CW)) bus ();

  sobel_frame_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .abort_i (abort_i),
    .stall_i (stall_i),
    .bus     (bus),
    .done_o  (done_o),
    .state_o (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Pixel k of a 4x4 frame: row k/4, col k%4, buffer row%3, window from (2,2).
  function automatic exp_t mk(int k, int gap);
    exp_t e;
    e.row  = 3'(k / 4);
    e.col  = 3'(k % 4);
    e.sel  = 2'((k / 4) % 3);
    e.win  = ((k / 4) >= 2) && ((k % 4) >= 2);
    e.done = (k == 15);
    e.gap  = gap;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({bus.lb_we_o, bus.lb_sel_o, bus.lb_addr_o, bus.row_o, bus.col_o,
                    bus.win_valid_o, done_o, state_o, bus.pix_ready_o}), 0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic run_frame();
    for (int k = 0; k < 16; k++) expq.push_back(mk(k, (k == 0) ? 0 : 1));
    bus.pix_valid_i = 1'b1;
    for (int k = 0; k < 16; k++) cyc();
    bus.pix_valid_i = 1'b0;
  endtask

  // Monitor: every negedge out of reset, either a write (checked against the
  // queue head) or no write (write-side outputs must hold the last written pixel).
  initial begin : monitor
    exp_t e;
    exp_t last;
    int   ncyc;
    int   last_we;
    last    = mk(0, 0);
    ncyc    = 0;
    last_we = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = mk(0, 0);
      end else begin
        ncyc++;
        if (done_o) done_cnt++;
        vectors++;
        if (bus.lb_we_o) begin
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: actual write row %0d col %0d, required no write",
                     bus.row_o, bus.col_o);
          end else begin
            e = expq.pop_front();
            if (bus.lb_sel_o !== e.sel || bus.lb_addr_o !== e.col || bus.row_o !== e.row ||
                bus.col_o !== e.col || bus.win_valid_o !== e.win || done_o !== e.done) begin
              miscompares++;
              $display("FAIL write: actual sel %0d addr %0d row %0d col %0d win %0d done %0d, required sel %0d addr %0d row %0d col %0d win %0d done %0d",
                       bus.lb_sel_o, bus.lb_addr_o, bus.row_o, bus.col_o, bus.win_valid_o, done_o,
                       e.sel, e.col, e.row, e.col, e.win, e.done);
            end
            if (e.gap != 0) chk("write_spacing", ncyc - last_we, e.gap);
            e.win  = 1'b0;
            e.done = 1'b0;
            last   = e;
          end
          last_we = ncyc;
        end else begin
          if (bus.lb_sel_o !== last.sel || bus.lb_addr_o !== last.col || bus.row_o !== last.row ||
              bus.col_o !== last.col || bus.win_valid_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: actual sel %0d addr %0d row %0d col %0d win %0d done %0d, required sel %0d addr %0d row %0d col %0d win 0 done 0",
                     bus.lb_sel_o, bus.lb_addr_o, bus.row_o, bus.col_o, bus.win_valid_o, done_o,
                     last.sel, last.col, last.row, last.col);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst             = 1'b0;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    stall_i         = 1'b0;
    bus.pix_valid_i = 1'b0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Full frame, continuous stream
    pulse_start();
    chk("s1_state_fill", state_o, 1);
    for (int k = 0; k < 16; k++) expq.push_back(mk(k, (k == 0) ? 0 : 1));
    bus.pix_valid_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("s1_state_px%0d", k), state_o, (k < 8) ? 1 : 2);
      chk($sformatf("s1_ready_px%0d", k), bus.pix_ready_o, 1);
      @(posedge clk);
      #1;
    end
    bus.pix_valid_i = 1'b0;
    #1;
    chk("s1_state_done", state_o, 3);
    chk("s1_ready_done", bus.pix_ready_o, 0);
    cyc();
    chk("s1_state_idle", state_o, 0);
    cyc();
    chk("s1_done_count", done_cnt, 1);

    // Back-pressure at pixel 5 for three cycles
    pulse_start();
    for (int k = 0; k < 16; k++) expq.push_back(mk(k, (k == 0) ? 0 : ((k == 5) ? 4 : 1)));
    bus.pix_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    stall_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1 chk($sformatf("s2_stall_ready%0d", s), bus.pix_ready_o, 0);
      @(posedge clk);
      #1;
    end
    stall_i = 1'b0;
    for (int k = 5; k < 16; k++) cyc();
    bus.pix_valid_i = 1'b0;
    cyc();
    cyc();
    chk("s2_done_count", done_cnt, 2);

    // Bubbles: valid alternates 1/0
    pulse_start();
    for (int k = 0; k < 16; k++) expq.push_back(mk(k, (k == 0) ? 0 : 2));
    for (int k = 0; k < 16; k++) begin
      bus.pix_valid_i = 1'b1;
      cyc();
      bus.pix_valid_i = 1'b0;
      if (k < 15) begin
        #1 chk($sformatf("s3_bubble_ready%0d", k), bus.pix_ready_o, 1);
      end
      cyc();
    end
    cyc();
    chk("s3_done_count", done_cnt, 3);
    chk("s3_state_idle", state_o, 0);

    // Abort in RUN at row 2, col 1 with a pixel presented
    pulse_start();
    for (int k = 0; k < 9; k++) expq.push_back(mk(k, (k == 0) ? 0 : 1));
    bus.pix_valid_i = 1'b1;
    for (int k = 0; k < 9; k++) cyc();
    abort_i = 1'b1;
    #1;
    chk("s4_abort_ready", bus.pix_ready_o, 0);
    chk("s4_abort_state", state_o, 2);
    @(posedge clk);
    #1;
    abort_i         = 1'b0;
    bus.pix_valid_i = 1'b0;
    chk("s4_after_abort_state", state_o, 0);
    cyc();
    cyc();
    chk("s4_no_done", done_cnt, 3);
    pulse_start();
    run_frame();
    cyc();
    cyc();
    chk("s4_restart_done_count", done_cnt, 4);

    // Asynchronous reset mid-frame: pixel 5 is accepted but its write is squashed
    pulse_start();
    for (int k = 0; k < 5; k++) expq.push_back(mk(k, (k == 0) ? 0 : 1));
    bus.pix_valid_i = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    #1 rst = 1'b1;
    #1 chk_all_zero("s5_async_reset");
    bus.pix_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("s5_state_after_reset", state_o, 0);
    cyc();
    chk("s5_no_done", done_cnt, 4);

    // start_i during DONE is ignored
    pulse_start();
    run_frame();
    start_i = 1'b1;
    #1 chk("s5_in_done", state_o, 3);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("s5_start_in_done_idle", state_o, 0);
    cyc();
    chk("s5_still_idle", state_o, 0);
    chk("s5_done_count", done_cnt, 5);

    // start_i and abort_i together in IDLE: start wins
    start_i = 1'b1;
    abort_i = 1'b1;
    cyc();
    start_i = 1'b0;
    abort_i = 1'b0;
    #1;
    chk("s5_start_abort_state", state_o, 1);
    chk("s5_start_abort_ready", bus.pix_ready_o, 1);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("s5_final_abort_state", state_o, 0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
    cyc();
    chk("queue_drained", expq.size(), 0);
    chk("final_done_count", done_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the Sobel edge-detection pipeline. Accepts the pixel stream from the memory controller through a valid/ready handshake, tracks row/column position, drives the write side of the three rotating line buffers in preprocess, and tells the core when a complete 3x3 window is available. Sits between the memory-controller interface and the preprocess/core datapath, and is the source of the top-level `state_o`.

## Interface
- `IMG_W`, 640: pixels per row, at least 3.
- `IMG_H`, 480: rows per frame, at least 3.
- `CW`, 10: counter width; 2^CW must be at least max(IMG_W, IMG_H).

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin frame; sampled only in IDLE.
- `abort_i` in 1: synchronous frame abort.
- `stall_i` in 1: core back-pressure; blocks acceptance.
- `pix_valid_i` in 1: memory controller has a pixel.
- `pix_ready_o` out 1: pixel accepted when high together with `pix_valid_i`.
- `lb_we_o` out 1: line-buffer write strobe, one per accepted pixel.
- `lb_sel_o` out 2: line buffer being written, 0..2.
- `lb_addr_o` out CW: column address of the write.
- `win_valid_o` out 1: 3x3 window centred at (row-1, col-1) is complete.
- `row_o` out CW: row of the pixel written this cycle.
- `col_o` out CW: column of the pixel written this cycle.
- `done_o` out 1: one-cycle end-of-frame pulse.
- `state_o` out 3: FSM state code.

## Operation
- **States:** IDLE=0, FILL=1, RUN=2, DONE=3. Codes 4..7 are unused; an unused code goes to IDLE on the next clock.
- **IDLE:**
  - `start_i` sets the internal counters `row` and `col` to 0, sets the write-select `sel` to 0, and moves to FILL.
  - `start_i` in any other state is ignored.
- **Acceptance:** `acc = pix_valid_i & pix_ready_o`.
  - `pix_ready_o = (state==FILL | state==RUN) & ~stall_i & ~abort_i`. This is combinational.
- **On acc, column/row advance:**
  - `col` increments. At `col==IMG_W-1`, `col` wraps to 0, `row` increments and `sel` advances 0->1->2->0.
- **On acc, state transitions:**
  - FILL->RUN when the accepted pixel is at row 1, col IMG_W-1.
  - RUN->DONE when the accepted pixel is at row IMG_H-1, col IMG_W-1.
- **DONE:** lasts one cycle, then goes to IDLE unconditionally. `pix_ready_o` is low.
- **Abort:** `abort_i` in FILL, RUN or DONE goes to IDLE next cycle.
  - Counters and `sel` are cleared.
  - No `done_o` pulse.
  - A pixel presented in the abort cycle is not accepted.
  - `abort_i` in IDLE has no effect.
- **Simultaneous `start_i` and `abort_i` in IDLE:** start wins.
- **Counter arithmetic:** unsigned, CW bits. Counters never exceed IMG_W-1 / IMG_H-1 inside a frame.

## Timing
- **Reset values:** all outputs and internal state are 0: state IDLE, `state_o=0`, `pix_ready_o=0`. Reset takes effect immediately, without waiting for a clock.
- **Write-side outputs** (`lb_we_o`, `lb_sel_o`, `lb_addr_o`, `row_o`, `col_o`, `win_valid_o`):
  - Registered; each describes the pixel accepted in the previous cycle.
  - `lb_we_o` is high for exactly one cycle per accepted pixel. When it is low, the other write-side outputs hold their last value.
- **`win_valid_o`:** equals `lb_we_o & (row_o>=2) & (col_o>=2)` for the same pixel, and is registered alongside it.
- **`done_o`:**
  - Registered; high for the one cycle the FSM is in DONE.
  - That cycle is the cycle after the final acceptance, so it coincides with the final `lb_we_o`.
- **`state_o`:** equals the current state register; no extra latency.
- **Throughput:** one pixel per cycle when `pix_valid_i=1` and `stall_i=0`.
- **`stall_i`:** may toggle any cycle. The counters hold while it is high.
- **Reset mid-frame:** returns to IDLE with no `done_o` pulse; the next frame needs a new `start_i`.
- **Start latency:** the first `pix_ready_o` is the cycle after `start_i` is sampled.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, CW=3.

1. **Full frame, continuous stream:** `start_i` pulse, `pix_valid_i` held high, 16 pixels.
   - 16 `lb_we_o` pulses on consecutive cycles, `lb_sel_o` sequence 0,0,0,0,1,1,1,1,2,...,0.
   - 4 `win_valid_o` pulses at (row,col) = (2,2),(2,3),(3,2),(3,3).
   - `state_o` goes 1 -> 2 after the 8th acceptance.
   - `done_o` is high for exactly one cycle, aligned with the 16th `lb_we_o`, then `state_o=0`.
2. **Back-pressure:** `stall_i` high for 3 cycles starting at pixel 5.
   - `pix_ready_o=0` for those cycles and no `lb_we_o`.
   - Afterwards the sequence resumes at row 1, col 1 with no skipped or duplicated address.
3. **Bubbles:** `pix_valid_i` alternates 1/0.
   - 16 `lb_we_o` pulses spaced 2 cycles apart.
   - `done_o` fires once.
4. **Abort:** `abort_i` asserted in RUN at row 2, col 1 with `pix_valid_i` high.
   - No acceptance that cycle; `state_o=0` next cycle; `done_o` never asserted.
   - A fresh `start_i` then begins writing at `lb_sel_o=0`, row 0, col 0.
5. **Asynchronous reset:** `rst` raised between clock edges mid-frame.
   - All outputs are 0 before the next edge.
   - `start_i` during DONE is ignored.
   - `start_i` and `abort_i` together in IDLE enter FILL.
